bitcnt_iter: RTL and testbench

BITCNT_ITER -- requirements
Module: bitcnt_iter

---
 rtl/bitcnt_iter.sv | 114 +++++++++++
 tb/tb_bitcnt_iter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bitcnt_iter.sv
// bitcnt_iter: iterative clz/ctz/cpop/clo/cto, CHUNK bits per cycle; BITCNT_ITER_EARLY_EXIT_EN enables early termination.
module bitcnt_iter #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [XLEN-1:0] din_data,
    input  logic [2:0]      din_func,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [XLEN-1:0] dout_data
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [XLEN-1:0] MASK32 = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [CW-1:0] W_FULL = CW'(XLEN);
    localparam logic [CW-1:0] W_HALF = CW'(32);
    localparam logic [CW-1:0] N_FULL = CW'(XLEN / CHUNK);
    localparam logic [CW-1:0] N_HALF = CW'(32 / CHUNK);

    logic [1:0]       state;
    logic [XLEN-1:0]  op;
    logic [CW-1:0]    cnt, steps, add, sum, w_lim, cnt_nx;
    logic             pop, lead, wop, found, last, early;
    logic             d_pop, d_inv, d_wop, d_lead;
    logic [CHUNK-1:0] c;

    function automatic logic [CW-1:0] lz(input logic [CHUNK-1:0] v);
        logic s;
        lz = '0;
        s = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            s = s | v[i];
            lz = lz + CW'(!s);
        end
    endfunction

    function automatic logic [CW-1:0] tz(input logic [CHUNK-1:0] v);
        logic s;
        tz = '0;
        s = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s | v[i];
            tz = tz + CW'(!s);
        end
    endfunction

    function automatic logic [CW-1:0] pc(input logic [CHUNK-1:0] v);
        pc = '0;
        for (int i = 0; i < CHUNK; i++) pc = pc + CW'(v[i]);
    endfunction

    // clo/cto are stored inverted so they reuse the leading/trailing-zero path
    always_comb begin
        d_pop  = din_func[2:1] == 2'b10;
        d_inv  = din_func[2:1] == 2'b11;
        d_wop  = din_func[0] & !d_inv;
        d_lead = din_func == 3'b110 || din_func[2:1] == 2'b00;
        c      = lead ? op[XLEN-1 -: CHUNK] : op[CHUNK-1:0];
        add    = pop ? pc(c) : found ? '0 : lead ? lz(c) : tz(c);
        sum    = cnt + add;
        w_lim  = wop ? W_HALF : W_FULL;
        cnt_nx = sum > w_lim ? w_lim : sum;
        last   = steps == (wop ? N_HALF : N_FULL) - CW'(1);
    end

`ifdef BITCNT_ITER_EARLY_EXIT_EN
    assign early = !pop && !found && |c;
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op    <= '0;
            cnt   <= '0;
            steps <= '0;
            found <= 1'b0;
            pop   <= 1'b0;
            lead  <= 1'b0;
            wop   <= 1'b0;
        end else if (state == IDLE) begin
            if (din_valid) begin
                state <= BUSY;
                op    <= d_wop ? (d_lead ? (din_data & MASK32) << (XLEN - 32) : din_data & MASK32)
                               : d_inv ? ~din_data : din_data;
                cnt   <= '0;
                steps <= '0;
                found <= 1'b0;
                pop   <= d_pop;
                lead  <= d_lead;
                wop   <= d_wop;
            end
        end else if (state == BUSY) begin
            op    <= lead ? op << CHUNK : op >> CHUNK;
            cnt   <= cnt_nx;
            found <= found | (!pop & |c);
            steps <= steps + CW'(1);
            if (last || early) state <= DONE;
        end else if (dout_ready || state != DONE) begin
            state <= IDLE;
        end
    end

    assign din_ready  = state == IDLE;
    assign dout_valid = state == DONE;
    assign dout_data  = dout_valid ? {{(XLEN-CW){1'b0}}, cnt} : '0;
endmodule

// File: tb/tb_bitcnt_iter.sv
// tb_bitcnt_iter: scoreboard bench for bitcnt_iter (XLEN=64, CHUNK=8).
module tb_bitcnt_iter;
    logic        clock = 0, reset = 1, din_valid = 0, dout_ready = 0;
    logic        din_ready, dout_valid;
    logic [63:0] din_data = '0, dout_data;
    logic [2:0]  din_func = '0;
    int passed = 0, total = 0;
    int exp_q[$], lat_q[$];

    always #5 clock = ~clock;

    bitcnt_iter #(.XLEN(64), .CHUNK(8)) dut (
        .clock(clock), .reset(reset), .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_func(din_func), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_data(dout_data)
    );

    function automatic int wid(input logic [2:0] f);
        return (f[0] && f[2:1] != 2'b11) ? 32 : 64;
    endfunction

    function automatic int model(input logic [2:0] f, input logic [63:0] d);
        logic [63:0] v;
        int w, n;
        w = wid(f);
        v = (f[2:1] == 2'b11) ? ~d : d;
        if (w == 32) v = {32'h0, v[31:0]};
        n = 0;
        if (f[2:1] == 2'b10) begin
            for (int i = 0; i < w; i++) n += int'(v[i]);
        end else if (f == 3'b000 || f == 3'b001 || f == 3'b110) begin
            for (int i = w - 1; i >= 0; i--) begin
                if (v[i]) break;
                n++;
            end
        end else begin
            for (int i = 0; i < w; i++) begin
                if (v[i]) break;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input int n);
`ifdef BITCNT_ITER_EARLY_EXIT_EN
        if (f[2:1] != 2'b10 && n < wid(f)) return n / 8 + 2;
`endif
        return wid(f) / 8 + 1;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [63:0] d);
        int n = model(f, d);
        din_valid = 1; din_func = f; din_data = d;
        exp_q.push_back(n);
        lat_q.push_back(exp_lat(f, n));
        @(posedge clock); #1;
        din_valid = 0; din_data = {$urandom, $urandom}; din_func = 3'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int rdy_busy);
        cyc = 1; rdy_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (dout_valid) break;
            if (din_ready) rdy_busy++;
            @(posedge clock);
            cyc++;
        end
    endtask

    task automatic take();
        dout_ready = 1;
        @(posedge clock); #1;
        dout_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (din_ready !== 1'b1) $display("FAIL reset_din_ready: got %0b expected 1", din_ready); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %0b expected 0", dout_valid); else passed++;
        total++; if (dout_data !== 64'h0) $display("FAIL reset_dout_data: got %0h expected 0", dout_data); else passed++;
        reset = 0;
        @(posedge clock); @(negedge clock);
        total++; if (din_ready !== 1'b1) $display("FAIL post_reset_din_ready: got %0b expected 1", din_ready); else passed++;
    endtask

    task automatic test_vectors();
        logic [2:0]  ft[15] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b111, 3'b000, 3'b010, 3'b110,
                                3'b111, 3'b010, 3'b011, 3'b110, 3'b001, 3'b100, 3'b011};
        logic [63:0] dt[15] = '{64'h0000_0001_0000_0000, '1, '1, 64'hFFFF_FFFF_0000_0000,
                                64'hFF, 64'h0, 64'h0, '1, '1, 64'h1, 64'h8000_0000_0000_0000,
                                64'hF000_0000_0000_0000, 64'h8000, 64'h0, 64'h0000_0000_0010_0000};
        int cyc, rb, e, l;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            issue(ft[i], dt[i]);
            wait_done(cyc, rb);
            e = exp_q.pop_front(); l = lat_q.pop_front();
            total++; if (dout_data !== 64'(e)) $display("FAIL vec%0d_data: got %0d expected %0d", i, dout_data, e); else passed++;
            total++; if (cyc != l) $display("FAIL vec%0d_latency: got %0d expected %0d", i, cyc, l); else passed++;
            total++; if (rb != 0) $display("FAIL vec%0d_busy_ready: got %0d expected 0", i, rb); else passed++;
            take();
        end
    endtask

    task automatic test_hold();
        int cyc, rb, e, l, extra;
        @(negedge clock);
        issue(3'b100, 64'h0123_4567_89AB_CDEF);
        wait_done(cyc, rb);
        e = exp_q.pop_front(); l = lat_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            total++; if (dout_valid !== 1'b1) $display("FAIL hold%0d_valid: got %0b expected 1", k, dout_valid); else passed++;
            total++; if (dout_data !== 64'(e)) $display("FAIL hold%0d_data: got %0d expected %0d", k, dout_data, e); else passed++;
            total++; if (din_ready !== 1'b0) $display("FAIL hold%0d_din_ready: got %0b expected 0", k, din_ready); else passed++;
            din_valid = 1; din_data = {$urandom, $urandom}; din_func = 3'($urandom);
            @(posedge clock); #1;
            din_valid = 0;
            @(negedge clock);
        end
        take();
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (dout_valid) extra++;
        end
        total++; if (extra != 0) $display("FAIL hold_no_queued: got %0d valid cycles expected 0", extra); else passed++;
    endtask

    task automatic test_idle_ready();
        int bad = 0;
        dout_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (dout_valid !== 1'b0 || din_ready !== 1'b1) bad++;
        end
        dout_ready = 0;
        total++; if (bad != 0) $display("FAIL idle_dout_ready: got %0d bad cycles expected 0", bad); else passed++;
    endtask

    task automatic test_abort();
        int extra = 0;
        @(negedge clock);
        issue(3'b000, 64'h1);
        repeat (3) @(negedge clock);
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        exp_q.delete(); lat_q.delete();
        @(negedge clock);
        total++; if (din_ready !== 1'b1) $display("FAIL abort_din_ready: got %0b expected 1", din_ready); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL abort_dout_valid: got %0b expected 0", dout_valid); else passed++;
        total++; if (dout_data !== 64'h0) $display("FAIL abort_dout_data: got %0h expected 0", dout_data); else passed++;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (dout_valid) extra++;
        end
        total++; if (extra != 0) $display("FAIL abort_no_result: got %0d valid cycles expected 0", extra); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ft[3] = '{3'b010, 3'b101, 3'b110};
        logic [63:0] dt[3] = '{64'h0000_0100_0000_0000, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FF00_0000_0000};
        int cyc, rb, e, l;
        @(negedge clock);
        issue(ft[0], dt[0]);
        for (int i = 0; i < 3; i++) begin
            wait_done(cyc, rb);
            e = exp_q.pop_front(); l = lat_q.pop_front();
            total++; if (dout_data !== 64'(e)) $display("FAIL b2b%0d_data: got %0d expected %0d", i, dout_data, e); else passed++;
            total++; if (cyc != l) $display("FAIL b2b%0d_latency: got %0d expected %0d", i, cyc, l); else passed++;
            take();
            @(negedge clock);
            total++; if (din_ready !== 1'b1) $display("FAIL b2b%0d_bubble_ready: got %0b expected 1", i, din_ready); else passed++;
            if (i < 2) issue(ft[i+1], dt[i+1]);
        end
    endtask

    task automatic test_random();
        int cyc, rb, e, l;
        logic [63:0] d;
        for (int i = 0; i < 24; i++) begin
            d = {$urandom, $urandom};
            if (i % 3 == 0) d = 64'h1 << $urandom_range(63);
            if (i % 3 == 1) d = ~(64'h1 << $urandom_range(63));
            @(negedge clock);
            issue(3'($urandom), d);
            wait_done(cyc, rb);
            e = exp_q.pop_front(); l = lat_q.pop_front();
            repeat ($urandom_range(2)) @(negedge clock);
            total++; if (dout_data !== 64'(e)) $display("FAIL rnd%0d_data: got %0d expected %0d", i, dout_data, e); else passed++;
            total++; if (cyc != l) $display("FAIL rnd%0d_latency: got %0d expected %0d", i, cyc, l); else passed++;
            take();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_idle_ready();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
